uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter between NUM_REQ byte-stream requesters. Each requester presents bytes with a valid/ready handshake and marks message end with a last flag. The grant is locked for a whole message, so messages from different clients never interleave on the serial line. Burst and idle-hold limits bound latency for the other requesters. The block drives the UART transmitter's txStart/txData and observes its txBusy.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, maximum bytes sent per grant before a forced re-arbitration
HOLD_TIMEOUT, 255, idle cycles a granted requester may leave req_valid low mid-message before its grant is revoked

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous assert, active-low
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  per-requester end-of-message, qualified by req_valid
req_ready  out  NUM_REQ  per-requester byte accepted this cycle (transfer = valid & ready)
grant  out  NUM_REQ  one-hot current owner; zero when idle
txBusy  in  1  UART transmitter busy
txStart  out  1  one-cycle pulse: start transmitting txData
txData  out  8  byte to transmit; held stable from txStart until next txStart
arb_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; grant=0, req_ready=0, txStart=0, txData=8'h00, arb_busy=0.
  - burst_cnt=0, hold_cnt=0, last_owner=NUM_REQ-1, so requester 0 has first priority.
- States:
  - IDLE: if any req_valid is high, select the first valid index searching last_owner+1, last_owner+2, ... modulo NUM_REQ. Register grant one-hot, clear burst_cnt and hold_cnt, go to SEND. Arbitration takes 1 cycle. The grant becomes visible in the cycle SEND is entered.
  - SEND: req_ready[g] is combinationally (state==SEND && !txBusy). All other req_ready bits are 0.
    - On transfer: next edge registers txData<=req_data[g] and txStart<=1, latches last_flag<=req_last[g], increments burst_cnt, clears hold_cnt, and goes to WAIT_ACK.
    - If req_valid[g]=0: hold_cnt increments. When hold_cnt reaches HOLD_TIMEOUT, release (see below).
  - WAIT_ACK: txStart returns to 0 after exactly one cycle. Stay until txBusy=1, then go to WAIT_DONE.
  - WAIT_DONE: stay while txBusy=1. On txBusy=0:
    - If last_flag=1 or burst_cnt==MAX_BURST, release.
    - Otherwise go to SEND.
- Release: last_owner<=g, grant<=0, go to IDLE. A re-grant needs the IDLE cycle, so the same requester cannot win twice in a row while another requester is valid.
- Latency: from req_valid rising (all idle, txBusy=0) to txStart high is 3 cycles: IDLE→SEND, transfer, txStart.
- Exactly one byte is in flight at a time. req_ready is never high while txBusy=1 or outside SEND.
- Changes to req_valid or req_data on non-granted requesters have no effect.
- Simultaneous req_last=1 and the MAX_BURST-th byte: a single release.
- txBusy already high on entering SEND: req_ready stays 0 until it falls. No byte is dropped.
- Reset mid-message: abort immediately to reset values. The in-flight UART byte is not tracked.
- burst_cnt width is clog2(MAX_BURST+1). hold_cnt width is clog2(HOLD_TIMEOUT+1). Neither counter wraps; both saturate at their compare value.

Test Plan:
- Reset, then req_valid=4'b0001 with bytes 0x41,0x42 (last on 0x42), UART model busy 10 cycles per byte → txData 0x41 then 0x42, one txStart each; grant=4'b0001 throughout; grant=0 after the final txBusy fall.
- All four requesters valid, each sending one-byte messages 0xA0+i with last=1 → service order 0,1,2,3,0; no requester is granted twice consecutively.
- Requester 1 streams 20 bytes with no last, MAX_BURST=16, requester 2 valid → after 16 bytes grant moves to requester 2; requester 1 resumes on its next turn with byte 17; no bytes lost or duplicated.
- Requester 0 granted, sends 1 byte without last, then drops req_valid for 300 cycles (HOLD_TIMEOUT=255) → grant released after 255 idle cycles in SEND; requester 3 pending receives the next grant.
- txBusy tied high when the grant is issued → req_ready stays 0 and txStart stays 0; after txBusy falls, the byte transfers within 1 cycle and txStart pulses once.
- rst asserted in WAIT_DONE mid-message → all outputs 0 at once; after release, requester 0 has priority again.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, grant vector and UART transmitter handshake shared by the arbiter.
// slave is the arbiter's view; master is the requesters' and transmitter's view.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   grant;
   logic                 txBusy;
   logic                 txStart;
   logic [7:0]           txData;
   logic                 arb_busy;

   modport slave (
      input  req_valid, req_data, req_last, txBusy,
      output req_ready, grant, txStart, txData, arb_busy
   );

   modport master (
      output req_valid, req_data, req_last, txBusy,
      input  req_ready, grant, txStart, txData, arb_busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter, grant locked per message; idle request to txStart is 3 cycles.
// req_ready only in SEND while txBusy is low, so exactly one byte is ever in flight.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int MAX_BURST    = 16,
   parameter int HOLD_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int IDX_W   = $clog2(NUM_REQ);
   localparam int BURST_W = $clog2(MAX_BURST + 1);
   localparam int HOLD_W  = $clog2(HOLD_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_ACK,
      S_WAIT_DONE
   } state_t;

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_grant;
   logic [IDX_W-1:0]     r_gidx;
   logic [IDX_W-1:0]     r_last_owner;
   logic [BURST_W-1:0]   r_burst_cnt;
   logic [HOLD_W-1:0]    r_hold_cnt;
   logic                 r_last_flag;
   logic                 r_txStart;
   logic [7:0]           r_txData;
   logic                 r_arb_busy;

   logic                 w_sel_found;
   logic [IDX_W-1:0]     w_sel_idx;
   logic [IDX_W-1:0]     w_cand;
   logic [NUM_REQ-1:0]   w_sel_onehot;
   logic                 w_gvalid;
   logic                 w_glast;
   logic [7:0]           w_gdata;
   logic                 w_send_open;
   logic                 w_xfer;
   logic                 w_burst_done;
   logic                 w_hold_expire;

   // Search starts just after the previous owner, so the last winner is considered last.
   always_comb begin
      w_sel_found  = 1'b0;
      w_sel_idx    = '0;
      w_cand       = '0;
      w_sel_onehot = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = IDX_W'((int'(r_last_owner) + k) % NUM_REQ);
         if (!w_sel_found && bus.req_valid[w_cand]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = w_cand;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_sel_idx == IDX_W'(i)) begin
            w_sel_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      w_gdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant[i]) begin
            w_gdata = w_gdata | bus.req_data[8*i +: 8];
         end
      end
   end

   assign w_gvalid      = |(bus.req_valid & r_grant);
   assign w_glast       = |(bus.req_last & r_grant);
   assign w_send_open   = (r_state == S_SEND) && !bus.txBusy;
   assign w_xfer        = w_send_open && w_gvalid;
   assign w_burst_done  = (r_burst_cnt == BURST_W'(MAX_BURST));
   // The idle cycle that brings hold_cnt up to HOLD_TIMEOUT is the one that releases.
   assign w_hold_expire = (r_hold_cnt >= HOLD_W'(HOLD_TIMEOUT - 1));

   assign bus.req_ready = w_send_open ? r_grant : '0;
   assign bus.grant     = r_grant;
   assign bus.txStart   = r_txStart;
   assign bus.txData    = r_txData;
   assign bus.arb_busy  = r_arb_busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_grant      <= '0;
         r_gidx       <= '0;
         r_last_owner <= IDX_W'(NUM_REQ - 1);
         r_burst_cnt  <= '0;
         r_hold_cnt   <= '0;
         r_last_flag  <= 1'b0;
         r_txStart    <= 1'b0;
         r_txData     <= 8'h00;
         r_arb_busy   <= 1'b0;
      end else begin
         r_txStart <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_sel_found) begin
                  r_grant     <= w_sel_onehot;
                  r_gidx      <= w_sel_idx;
                  r_burst_cnt <= '0;
                  r_hold_cnt  <= '0;
                  r_arb_busy  <= 1'b1;
                  r_state     <= S_SEND;
               end
            end
            S_SEND: begin
               if (w_xfer) begin
                  r_txData    <= w_gdata;
                  r_txStart   <= 1'b1;
                  r_last_flag <= w_glast;
                  r_hold_cnt  <= '0;
                  if (!w_burst_done) begin
                     r_burst_cnt <= r_burst_cnt + BURST_W'(1);
                  end
                  r_state     <= S_WAIT_ACK;
               end else if (!w_gvalid) begin
                  if (w_hold_expire) begin
                     r_hold_cnt   <= HOLD_W'(HOLD_TIMEOUT);
                     r_last_owner <= r_gidx;
                     r_grant      <= '0;
                     r_arb_busy   <= 1'b0;
                     r_state      <= S_IDLE;
                  end else begin
                     r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                  end
               end
            end
            S_WAIT_ACK: begin
               if (bus.txBusy) begin
                  r_state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (!bus.txBusy) begin
                  // End of message and burst exhaustion in the same byte give one release.
                  if (r_last_flag || w_burst_done) begin
                     r_last_owner <= r_gidx;
                     r_grant      <= '0;
                     r_arb_busy   <= 1'b0;
                     r_state      <= S_IDLE;
                  end else begin
                     r_state <= S_SEND;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues, a UART busy model and an ordered scoreboard
// of {grant, txData} checked at every txStart.
module tb_uart_tx_arbiter;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NR)) u_if ();

   uart_tx_arbiter #(
      .NUM_REQ     (NR),
      .MAX_BURST   (16),
      .HOLD_TIMEOUT(255)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(u_if)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   logic [8:0]    rmem [NR][64];
   int            rhead [NR];
   int            rtail [NR];
   logic [11:0]   sb [$];
   logic [NR-1:0] drv_v;
   logic [NR-1:0] drv_l;
   logic [8*NR-1:0] drv_d;

   int   uart_n     = 3;
   int   uart_cnt   = 0;
   logic tie_busy   = 1'b0;
   logic prev_start = 1'b0;
   logic [11:0] sb_exp;

   assign u_if.txBusy = (uart_cnt != 0) || tie_busy;

   task automatic load(input int r, input logic [7:0] d, input logic last);
      rmem[r][rtail[r]] = {last, d};
      rtail[r]++;
   endtask

   task automatic expect_b(input int r, input logic [7:0] d);
      sb.push_back({4'(1 << r), d});
   endtask

   // Requesters: present the queue head on the falling edge, retire it once valid & ready is seen.
   always @(negedge clk) begin
      for (int i = 0; i < NR; i++) begin
         drv_v[i]         = rhead[i] < rtail[i];
         drv_d[8*i +: 8]  = rmem[i][rhead[i]][7:0];
         drv_l[i]         = rmem[i][rhead[i]][8];
      end
      u_if.req_valid = drv_v;
      u_if.req_data  = drv_d;
      u_if.req_last  = drv_l;
      #1;
      check("ready_while_busy", 32'(u_if.req_ready & {NR{u_if.txBusy}}), 0);
      check("ready_outside_grant", 32'(u_if.req_ready & ~u_if.grant), 0);
      for (int i = 0; i < NR; i++) begin
         if (drv_v[i] && u_if.req_ready[i]) rhead[i]++;
      end
   end

   // UART model: busy for uart_n cycles after each txStart; every txStart is scored.
   always @(negedge clk) begin
      if (!rst) begin
         uart_cnt   = 0;
         prev_start = 1'b0;
      end else begin
         if (uart_cnt > 0) uart_cnt--;
         if (u_if.txStart) begin
            check("txStart_one_cycle", 32'(prev_start), 0);
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               sb_exp = sb.pop_front();
               check("grant_txData", 32'({u_if.grant, u_if.txData}), 32'(sb_exp));
            end
            if (uart_cnt == 0) uart_cnt = uart_n;
         end
         prev_start = u_if.txStart;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #3;
      rst = 1'b0;
      for (int i = 0; i < NR; i++) begin
         rhead[i] = 0;
         rtail[i] = 0;
      end
      sb.delete();
      tie_busy = 1'b0;
      #1;
      check("rst_grant", 32'(u_if.grant), 0);
      check("rst_ready", 32'(u_if.req_ready), 0);
      check("rst_txStart", 32'(u_if.txStart), 0);
      check("rst_txData", 32'(u_if.txData), 0);
      check("rst_arb_busy", 32'(u_if.arb_busy), 0);
      @(negedge clk);
      @(negedge clk);
      #3;
      rst = 1'b1;
   endtask

   task automatic wait_drain(input int bound);
      int c = 0;
      while ((sb.size() != 0 || u_if.arb_busy || u_if.txBusy) && c < bound) begin
         @(negedge clk);
         #2;
         c++;
      end
      check("drain_in_time", 32'(c < bound), 1);
      check("sb_empty", 32'(sb.size()), 0);
      for (int i = 0; i < NR; i++) check("all_bytes_taken", 32'(rtail[i] - rhead[i]), 0);
   endtask

   task automatic wait_sb(input int left, input int bound);
      int c = 0;
      while (sb.size() > left && c < bound) begin
         @(negedge clk);
         #2;
         c++;
      end
      check("sb_reached", 32'(sb.size()), 32'(left));
   endtask

   task automatic wait_busy_fall(input int bound);
      int c = 0;
      while (u_if.txBusy && c < bound) begin
         @(negedge clk);
         #2;
         c++;
      end
      check("busy_fell", 32'(u_if.txBusy), 0);
   endtask

   typedef struct {
      logic [NR-1:0] mask;
      logic [NR-1:0] exp_grant;
   } vec_t;

   vec_t vt [6];
   logic [NR-1:0] first_g;
   int lat;
   int cnt;
   int c;

   initial begin
      vt[0] = '{4'b0001, 4'b0001};
      vt[1] = '{4'b1000, 4'b1000};
      vt[2] = '{4'b0110, 4'b0010};
      vt[3] = '{4'b1100, 4'b0100};
      vt[4] = '{4'b1111, 4'b0001};
      vt[5] = '{4'b1010, 4'b0010};

      #1 rst = 1'b0;

      // Fresh reset each row: requester 0 has first priority, service is ascending order.
      for (int t = 0; t < 6; t++) begin
         uart_n = 3;
         do_reset();
         for (int i = 0; i < NR; i++) begin
            if (vt[t].mask[i]) begin
               load(i, 8'(8'hA0 + i), 1'b1);
               expect_b(i, 8'(8'hA0 + i));
            end
         end
         first_g = '0;
         lat     = 0;
         @(negedge clk);
         for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            #2;
            if (first_g == '0) first_g = u_if.grant;
            if (u_if.txStart) lat = k;
         end
         check("first_grant", 32'(first_g), 32'(vt[t].exp_grant));
         // valid presented in cycle 1, SEND in cycle 2, txStart visible in cycle 3
         check("req_to_txStart", 32'(lat), 2);
         wait_drain(500);
      end

      // Two-byte message with a slow UART; grant held until the final busy fall.
      uart_n = 10;
      do_reset();
      load(0, 8'h41, 1'b0);
      load(0, 8'h42, 1'b1);
      expect_b(0, 8'h41);
      expect_b(0, 8'h42);
      c = 0;
      while (sb.size() != 0 && c < 200) begin
         @(negedge clk);
         #2;
         c++;
         if (u_if.arb_busy) check("t1_grant_held", 32'(u_if.grant), 32'h1);
      end
      check("t1_sb_drained", 32'(sb.size()), 0);
      wait_busy_fall(50);
      check("t1_grant_at_busy_fall", 32'(u_if.grant), 32'h1);
      @(negedge clk);
      #2;
      check("t1_grant_released", 32'(u_if.grant), 0);
      wait_drain(100);

      // All four valid, requester 0 has a second message: order 0,1,2,3,0.
      uart_n = 3;
      do_reset();
      load(0, 8'hA0, 1'b1);
      load(0, 8'hB0, 1'b1);
      load(1, 8'hA1, 1'b1);
      load(2, 8'hA2, 1'b1);
      load(3, 8'hA3, 1'b1);
      expect_b(0, 8'hA0);
      expect_b(1, 8'hA1);
      expect_b(2, 8'hA2);
      expect_b(3, 8'hA3);
      expect_b(0, 8'hB0);
      wait_drain(500);

      // Requester 1 streams 20 bytes without last; the burst limit hands over to requester 2 after 16.
      do_reset();
      for (int k = 0; k < 20; k++) load(1, 8'(8'h10 + k), 1'b0);
      load(2, 8'h77, 1'b1);
      for (int k = 0; k < 16; k++) expect_b(1, 8'(8'h10 + k));
      expect_b(2, 8'h77);
      for (int k = 16; k < 20; k++) expect_b(1, 8'(8'h10 + k));
      wait_drain(2000);

      // Hold timeout: one byte without last, then requester 0 goes quiet; requester 3 waits.
      do_reset();
      load(0, 8'h55, 1'b0);
      load(3, 8'h33, 1'b1);
      expect_b(0, 8'h55);
      expect_b(3, 8'h33);
      wait_sb(1, 100);
      wait_busy_fall(50);
      // one WAIT_DONE cycle after the busy fall plus 255 idle cycles in SEND
      cnt = 0;
      c   = 0;
      while (u_if.grant == 4'b0001 && c < 400) begin
         cnt++;
         @(negedge clk);
         #2;
         c++;
      end
      check("hold_grant_cycles", 32'(cnt), 256);
      check("hold_idle_gap", 32'(u_if.grant), 0);
      @(negedge clk);
      #2;
      check("hold_next_owner", 32'(u_if.grant), 32'h8);
      wait_drain(200);

      // Transmitter already busy when the grant arrives: nothing moves until it drops.
      do_reset();
      tie_busy = 1'b1;
      load(2, 8'h5A, 1'b1);
      expect_b(2, 8'h5A);
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #2;
         check("busy_no_ready", 32'(u_if.req_ready), 0);
         check("busy_no_txStart", 32'(u_if.txStart), 0);
      end
      check("busy_grant", 32'(u_if.grant), 32'h4);
      @(negedge clk);
      tie_busy = 1'b0;
      @(negedge clk);
      #2;
      check("busy_release_txStart", 32'(u_if.txStart), 1);
      wait_drain(200);

      // Reset lands in WAIT_DONE of a multi-byte message; priority returns to requester 0.
      uart_n = 10;
      do_reset();
      load(2, 8'h61, 1'b0);
      load(2, 8'h62, 1'b0);
      load(2, 8'h63, 1'b1);
      expect_b(2, 8'h61);
      wait_sb(0, 100);
      check("mid_busy", 32'(u_if.txBusy), 1);
      @(negedge clk);
      @(negedge clk);
      check("mid_owner", 32'(u_if.grant), 32'h4);
      do_reset();
      uart_n = 3;
      load(3, 8'h33, 1'b1);
      load(0, 8'h30, 1'b1);
      expect_b(0, 8'h30);
      expect_b(3, 8'h33);
      wait_drain(300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule
